// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment driver. A 13-bit binary value becomes BCD
// through a serial double-dabble converter, and the digits are scanned with a refresh counter.
module ssd_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] value,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        busy
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [3:0] LAST_STEP = 4'd12;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [12:0]      last_val_q, last_val_d;
  logic [28:0]      shift_q, shift_d;
  logic [15:0]      digits_q, digits_d;
  logic [CNT_W-1:0] refresh_q, refresh_d;
  logic [1:0]       sel_q, sel_d;

  logic [28:0] adjusted;
  logic [3:0]  nibble;
  logic        blank;

  function automatic logic [15:0] dd_adjust(input logic [15:0] bcd);
    logic [15:0] res;
    res = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign adjusted = {dd_adjust(shift_q[28:13]), shift_q[12:0]};

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    last_val_d = last_val_q;
    shift_d    = shift_q;
    digits_d   = digits_q;
    case (state_q)
      IDLE: begin
        if (value != last_val_q) begin
          shift_d    = {16'd0, value};
          last_val_d = value;
          step_d     = 4'd0;
          state_d    = CONV;
        end
      end
      CONV: begin
        shift_d = {adjusted[27:0], 1'b0};
        step_d  = step_q + 4'd1;
        // Only the final shift publishes, so the display never sees a half-converted value.
        if (step_q == LAST_STEP) begin
          digits_d = shift_d[28:13];
          step_d   = 4'd0;
          state_d  = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    refresh_d = refresh_q + CNT_W'(1);
    sel_d     = sel_q;
    if (refresh_q == CNT_MAX) begin
      refresh_d = '0;
      sel_d     = sel_q + 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the shift register is reset too; it is small, and a known value keeps the aborted-conversion path deterministic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= 4'd0;
      last_val_q <= 13'd0;
      shift_q    <= 29'd0;
      digits_q   <= 16'd0;
      refresh_q  <= '0;
      sel_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      last_val_q <= last_val_d;
      shift_q    <= shift_d;
      digits_q   <= digits_d;
      refresh_q  <= refresh_d;
      sel_q      <= sel_d;
    end
  end

  assign busy = (state_q == CONV);

  // Display path depends only on registered select and digits.
  always_comb begin
    nibble = digits_q[{sel_q, 2'b00} +: 4];
    case (sel_q)
      2'd1:    blank = (digits_q[15:4] == 12'd0);
      2'd2:    blank = (digits_q[15:8] == 8'd0);
      2'd3:    blank = (digits_q[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
    blank = blank & BLANK_LZ;
    anode = ~(4'b0001 << sel_q);
    seg   = blank ? 7'b1111111 : seg_decode(nibble);
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver: two instances (leading-zero blanking on/off,
// different refresh divisors) compared every cycle against a decimal-arithmetic reference model.
module tb_ssd_scan_driver;

  localparam int DIV_A = 4;
  localparam int DIV_B = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] value = 13'd0;
  logic [3:0]  anode_a, anode_b;
  logic [6:0]  seg_a, seg_b;
  logic        busy_a, busy_b;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_last, m_conv_val, m_disp, m_left;
  int m_cnt_a, m_sel_a, m_cnt_b, m_sel_b;
  int p10[4] = '{1, 10, 100, 1000};

  ssd_scan_driver #(.REFRESH_DIV(DIV_A), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .rst(rst), .value(value), .anode(anode_a), .seg(seg_a), .busy(busy_a)
  );

  ssd_scan_driver #(.REFRESH_DIV(DIV_B), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .rst(rst), .value(value), .anode(anode_b), .seg(seg_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int disp, input int pos, input bit blz);
    if (blz && pos > 0 && disp < p10[pos]) return 7'b1111111;
    return seg_of((disp / p10[pos]) % 10);
  endfunction

  function automatic logic [3:0] exp_anode(input int pos);
    logic [3:0] a;
    a = 4'b1111;
    a[pos] = 1'b0;
    return a;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_last = 0; m_conv_val = 0; m_disp = 0; m_left = 0;
      m_cnt_a = 0; m_sel_a = 0; m_cnt_b = 0; m_sel_b = 0;
    end else begin
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_disp = m_conv_val;
      end else if (int'(value) != m_last) begin
        m_last     = int'(value);
        m_conv_val = int'(value);
        m_left     = 13;
      end
      if (m_cnt_a == DIV_A - 1) begin m_cnt_a = 0; m_sel_a = (m_sel_a + 1) % 4; end
      else m_cnt_a++;
      if (m_cnt_b == DIV_B - 1) begin m_cnt_b = 0; m_sel_b = (m_sel_b + 1) % 4; end
      else m_cnt_b++;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_busy_a"},  32'(busy_a),  32'(m_left > 0));
    check({tag, "_busy_b"},  32'(busy_b),  32'(m_left > 0));
    check({tag, "_anode_a"}, 32'(anode_a), 32'(exp_anode(m_sel_a)));
    check({tag, "_seg_a"},   32'(seg_a),   32'(exp_seg(m_disp, m_sel_a, 1'b1)));
    check({tag, "_anode_b"}, 32'(anode_b), 32'(exp_anode(m_sel_b)));
    check({tag, "_seg_b"},   32'(seg_b),   32'(exp_seg(m_disp, m_sel_b, 1'b0)));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    // Reset state
    rst = 1'b1; value = 13'd0;
    run("reset", 2);
    check("reset_anode", 32'(anode_a), 32'(4'b1110));
    check("reset_seg",   32'(seg_a),   32'(7'b1000000));
    check("reset_busy",  32'(busy_a),  32'(1'b0));

    // Zero after reset must not start a conversion
    rst = 1'b0;
    run("zero_idle", 6);

    // Full-scale value: 13 busy edges, then 8191 on the display, then a full scan
    value = 13'd8191;
    tick("cap8191");
    check("cap8191_busy", 32'(busy_a), 32'(1'b1));
    run("conv8191", 12);
    check("conv8191_busy_last", 32'(busy_a), 32'(1'b1));
    tick("done8191");
    check("done8191_busy", 32'(busy_a), 32'(1'b0));
    run("scan8191", 4 * DIV_A * 2);

    // Leading-zero blanking on dut_a, none on dut_b
    value = 13'd7;
    run("val7", 14 + 4 * DIV_B * 2);

    // Change during conversion is ignored until the next idle edge
    value = 13'd100;
    tick("cap100");
    run("conv100", 4);
    value = 13'd250;
    run("conv100_late", 9);
    check("done100_busy", 32'(busy_a), 32'(1'b0));
    tick("cap250");
    check("cap250_busy", 32'(busy_a), 32'(1'b1));
    run("show250", 13 + 4 * DIV_B);

    // Reset in the middle of a conversion
    value = 13'd4095;
    tick("cap4095");
    run("conv4095", 6);
    rst = 1'b1;
    tick("abort");
    rst = 1'b0;
    check("abort_busy",  32'(busy_a),  32'(1'b0));
    check("abort_anode", 32'(anode_a), 32'(4'b1110));
    check("abort_seg",   32'(seg_a),   32'(7'b1000000));
    tick("recap4095");
    check("recap4095_busy", 32'(busy_a), 32'(1'b1));
    run("show4095", 13 + 4 * DIV_B);

    // Randomized values, hold times and occasional resets
    for (int k = 0; k < 40; k++) begin
      value = 13'($urandom_range(0, 8191));
      rst   = ($urandom_range(0, 9) == 0);
      tick("rnd");
      rst = 1'b0;
      run("rnd", $urandom_range(1, 30));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ssd_scan_driver.md
SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, meaning clk cycles per digit slot, legal range 2..2^20.
REQ-002 Parameter BLANK_LZ, default 1, meaning 1 = blank leading zero digits, 0 = show all four digits.
REQ-003 Port clk, input, 1, meaning sole clock, all state changes on rising edge.
REQ-004 Port rst, input, 1, meaning reset, synchronous and active-high.
REQ-005 Port value, input, 13, meaning unsigned binary to display (0..8191), the core's SSD bus.
REQ-006 Port anode, output, 4, meaning digit enables, active-low, one-hot-zero; bit0 = ones digit.
REQ-007 Port seg, output, 7, meaning segments {g,f,e,d,c,b,a}, active-low.
REQ-008 Port busy, output, 1, meaning high while a binary-to-BCD conversion is in progress.

Function
REQ-009 Converter FSM SHALL have exactly two states: IDLE and CONV.
REQ-010 In IDLE, on an edge where value != last_val, SHALL load shift register with value, set last_val <= value, clear step count, and enter CONV.
REQ-011 In IDLE with value == last_val, SHALL hold all state.
REQ-012 In CONV, each edge SHALL apply double-dabble: add 3 to every BCD nibble >= 5, then shift the 29-bit {bcd[15:0], bin[12:0]} register left by 1.
REQ-013 CONV SHALL last exactly 13 edges; on the 13th edge, digits register <= resulting 16-bit BCD and FSM -> IDLE.
REQ-014 Latency: digits SHALL reflect a new value 14 edges after the capture edge sees it (1 capture + 13 shifts).
REQ-015 busy SHALL equal (state == CONV).
REQ-016 value changes during CONV SHALL be ignored; the differing value SHALL be captured on the first IDLE edge afterwards.
REQ-017 Digits register SHALL change only on the final CONV edge; display never shows partial results.
REQ-018 Refresh counter SHALL count 0..REFRESH_DIV-1 every clk and wrap to 0.
REQ-019 On the wrap edge, 2-bit digit select SHALL increment 0->1->2->3->0.
REQ-020 anode SHALL be 4'b1110, 4'b1101, 4'b1011, 4'b0111 for select 0,1,2,3.
REQ-021 seg SHALL decode the selected BCD nibble: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-022 Nibbles 10..15 (unreachable) SHALL decode to 1111111.
REQ-023 With BLANK_LZ=1, a digit SHALL show 1111111 if it and all higher digits are zero; the ones digit is never blanked.
REQ-024 anode and seg SHALL be combinational from select and digits registers only (no path from value).
REQ-025 Converter and refresh logic SHALL run independently; a conversion completing mid-slot updates seg within the same slot.

Reset
REQ-026 With rst high at an edge: state IDLE, step count 0, last_val 0, digits 0, refresh counter 0, select 0.
REQ-027 Resulting outputs: anode = 4'b1110, seg = 7'b1000000, busy = 0.
REQ-028 rst during CONV SHALL abort the conversion; the partial result is discarded and digits = 0.
REQ-029 After reset with value = 0, no conversion SHALL start.

Verification
REQ-030 Reset, value = 8191 -> busy high for 13 edges; digits = 8,1,9,1 (thousands..ones) 14 edges after capture; busy then 0.
REQ-031 REFRESH_DIV=4, value = 8191 settled -> anode cycles 1110,1101,1011,0111 every 4 clk; seg 1111001, 0010000, 1111001, 0000000.
REQ-032 BLANK_LZ=1, value = 7 -> ones seg 1111000; tens, hundreds, thousands seg 1111111; BLANK_LZ=0 -> those show 1000000.
REQ-033 value 100 -> 250 on the 5th CONV edge -> first conversion completes showing 100; the next IDLE edge captures 250; 250 displayed 14 edges later.
REQ-034 rst asserted at CONV edge 7 of value = 4095 -> next cycle busy = 0, digits 0, anode 1110, seg 1000000; reconversion of 4095 starts after rst deasserts.
